// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR filter.
// Optional feature macro: FIR_SAT_EN (output saturation instead of wrap).
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2
    } fir_state_t;

    // Accumulator width that can hold the sum of all tap products without overflow.
    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Half an LSB of the output, added before the arithmetic shift (round-half-up).
    function automatic int round_half(input int frac_bits);
        return 1 << (frac_bits - 1);
    endfunction

    // Clamp a signed value into the range of a data_w-bit two's-complement number.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int data_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file for the TDM FIR. Resets to a moving-average kernel,
// accepts writes only when the filter is idle, and serves one tap per cycle.
// If a write coincides with a sample being accepted, the overwritten value is
// remembered so that sample still filters with the coefficient it was accepted under.
module fir_coef_bank #(
    parameter int COEF_W    = 8,
    parameter int TAPS      = 8,
    parameter int FRAC_BITS = 7
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [$clog2(TAPS)-1:0]    wr_addr,
    input  logic signed [COEF_W-1:0]   wr_data,
    input  logic                       accept,
    input  logic [$clog2(TAPS)-1:0]    rd_addr,
    output logic signed [COEF_W-1:0]   rd_data
);

    localparam int AW = $clog2(TAPS);
    localparam logic signed [COEF_W-1:0] COEF_RESET = COEF_W'((1 << FRAC_BITS) / TAPS);

    logic signed [COEF_W-1:0] coef [TAPS];
    logic                     in_range;
    logic                     shadow_valid;
    logic [AW-1:0]            shadow_addr;
    logic signed [COEF_W-1:0] shadow_data;

    assign in_range = ({1'b0, wr_addr} < (AW + 1)'(TAPS));

    for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef
        // One coefficient register; addresses beyond the last tap never match.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                coef[gi] <= COEF_RESET;
            end else if (wr_en && (wr_addr == AW'(gi))) begin
                coef[gi] <= wr_data;
            end
        end
    end

    // Capture the pre-write value when a write lands on the accepting edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_valid <= 1'b0;
            shadow_addr  <= '0;
            shadow_data  <= '0;
        end else if (accept) begin
            shadow_valid <= wr_en && in_range;
            shadow_addr  <= wr_addr;
            shadow_data  <= coef[wr_addr];
        end
    end

    assign rd_data = (shadow_valid && (shadow_addr == rd_addr)) ? shadow_data : coef[rd_addr];

endmodule

// File: rtl/fir_filter_tdm.sv
// Time-multiplexed signed FIR: TAPS-deep delay line, one shared multiplier,
// programmable coefficients, valid/ready handshakes on both sides.
// Optional feature macro: FIR_SAT_EN clamps the rounded result and drives sat_flag;
// without it the output wraps and sat_flag stays 0.
module fir_filter_tdm
    import fir_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 8,
    parameter int TAPS      = 8,
    parameter int FRAC_BITS = 7
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic signed [DATA_W-1:0]   data_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [DATA_W-1:0]   data_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_wdata,
    output logic                       sat_flag
);

    localparam int AW     = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
    localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(round_half(FRAC_BITS));
    localparam logic [AW-1:0] LAST_K = AW'(TAPS - 1);

    fir_state_t               state;
    fir_state_t               state_next;
    logic                     accept;
    logic                     last;
    logic [AW-1:0]            k;
    logic signed [DATA_W-1:0] x [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [DATA_W-1:0] x_sel;
    logic signed [COEF_W-1:0] h_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [DATA_W-1:0] result;
    logic                     result_sat;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign last     = (state == MAC) && (k == LAST_K);

    fir_coef_bank #(
        .COEF_W    (COEF_W),
        .TAPS      (TAPS),
        .FRAC_BITS (FRAC_BITS)
    ) u_coef_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (coef_we && in_ready),
        .wr_addr (coef_addr),
        .wr_data (coef_wdata),
        .accept  (accept),
        .rd_addr (k),
        .rd_data (h_sel)
    );

    for (genvar gi = 0; gi < TAPS; gi++) begin : g_delay
        if (gi == 0) begin : g_head
            // Newest sample enters at tap 0 when a sample is accepted.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    x[0] <= '0;
                end else if (accept) begin
                    x[0] <= data_in;
                end
            end
        end else begin : g_tail
            // Older samples move one tap further on each accepted sample.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    x[gi] <= '0;
                end else if (accept) begin
                    x[gi] <= x[gi-1];
                end
            end
        end
    end

    assign x_sel    = x[k];
    assign prod     = x_sel * h_sel;
    assign acc_next = acc + ACC_W'(prod);

`ifdef FIR_SAT_EN
    logic signed [ACC_W-1:0] rounded;
    logic signed [63:0]      rnd_wide;
    logic signed [63:0]      clamped;

    // Round the final sum and clamp it into the output range.
    always_comb begin
        rounded    = (acc_next + ROUND_C) >>> FRAC_BITS;
        rnd_wide   = {{(64 - ACC_W){rounded[ACC_W-1]}}, rounded};
        clamped    = saturate(rnd_wide, DATA_W);
        result     = clamped[DATA_W-1:0];
        result_sat = (clamped != rnd_wide);
    end
`else
    // Round the final sum and keep the low DATA_W bits (two's-complement wrap).
    always_comb begin
        result     = DATA_W'((acc_next + ROUND_C) >>> FRAC_BITS);
        result_sat = 1'b0;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: accept -> accumulate TAPS products -> hold until taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)     state_next = MAC;
            MAC:     if (last)       state_next = HOLD;
            HOLD:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Tap counter, accumulator and output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k         <= '0;
            acc       <= '0;
            data_out  <= '0;
            sat_flag  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        k   <= '0;
                        acc <= '0;
                    end
                end
                MAC: begin
                    if (last) begin
                        data_out  <= result;
                        sat_flag  <= result_sat;
                        out_valid <= 1'b1;
                    end else begin
                        acc <= acc_next;
                        k   <= k + AW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
